// File: rtl/instr_queue_register.sv
// DEPTH-entry instruction prefetch queue with a valid/ready fill side and an
// advance/flush control side; the head word is decoded into the instruction fields.
module instr_queue_register #(
    parameter int IW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic [IW-1:0] Din,
    input  logic          Din_valid,
    output logic          Din_ready,
    input  logic          Advance,
    input  logic          Flush,
    output logic          Valid,
    output logic [CW-1:0] Count,
    output logic [3:0]    Opcode,
    output logic [3:0]    funct,
    output logic [IW-5:0] Imm,
    output logic [2:0]    RegSelect,
    output logic [2:0]    RegSelect2,
    output logic [3:0]    Delta,
    output logic          LocationSelect
);

    localparam int PW = $clog2(DEPTH);

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic [IW-1:0] head;

    // Ready depends only on the registered count, so Advance never unblocks a full queue.
    assign Din_ready = (count_q != CW'(DEPTH));
    assign Valid     = (count_q != '0);
    assign Count     = count_q;

    assign push = Din_valid & Din_ready & ~Flush;
    assign pop  = Advance & Valid & ~Flush;

    always_ff @(posedge CLK) begin
        if (Reset || Flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage is not reset; only the pointers and count define what is live.
    always_ff @(posedge CLK) begin
        if (push && !Reset) begin
            mem[wr_ptr] <= Din;
        end
    end

    // An empty queue presents the all-zero NOP word.
    assign head = Valid ? mem[rd_ptr] : '0;

    assign Opcode         = head[IW-1 -: 4];
    assign funct          = head[IW-5 -: 4];
    assign Imm            = head[IW-5:0];
    assign RegSelect      = head[7:5];
    assign RegSelect2     = head[3:1];
    assign Delta          = head[4:1];
    assign LocationSelect = head[0];

endmodule

// File: tb/tb_instr_queue_register.sv
// Self-checking bench for instr_queue_register: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_instr_queue_register;

    localparam int IW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          Reset;
    logic [IW-1:0] Din;
    logic          Din_valid;
    logic          Din_ready;
    logic          Advance;
    logic          Flush;
    logic          Valid;
    logic [CW-1:0] Count;
    logic [3:0]    Opcode;
    logic [3:0]    funct;
    logic [IW-5:0] Imm;
    logic [2:0]    RegSelect;
    logic [2:0]    RegSelect2;
    logic [3:0]    Delta;
    logic          LocationSelect;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] model_q[$];

    typedef struct packed {
        logic          rst;
        logic          fl;
        logic          dv;
        logic          adv;
        logic [IW-1:0] din;
        logic          ev;
        logic [3:0]    ecnt;
        logic          erdy;
        logic [IW-1:0] ehead;
    } vec_t;

    vec_t vecs[13];

    always #5 CLK = ~CLK;

    instr_queue_register #(.IW(IW), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .Din(Din),
        .Din_valid(Din_valid),
        .Din_ready(Din_ready),
        .Advance(Advance),
        .Flush(Flush),
        .Valid(Valid),
        .Count(Count),
        .Opcode(Opcode),
        .funct(funct),
        .Imm(Imm),
        .RegSelect(RegSelect),
        .RegSelect2(RegSelect2),
        .Delta(Delta),
        .LocationSelect(LocationSelect)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input int ecnt,
                             input logic erdy, input logic [IW-1:0] eh);
        chk({tag, " Valid"}, 32'(Valid), 32'(ev));
        chk({tag, " Count"}, 32'(Count), 32'(ecnt));
        chk({tag, " Din_ready"}, 32'(Din_ready), 32'(erdy));
        chk({tag, " Opcode"}, 32'(Opcode), 32'(eh[15:12]));
        chk({tag, " funct"}, 32'(funct), 32'(eh[11:8]));
        chk({tag, " Imm"}, 32'(Imm), 32'(eh[11:0]));
        chk({tag, " RegSelect"}, 32'(RegSelect), 32'(eh[7:5]));
        chk({tag, " RegSelect2"}, 32'(RegSelect2), 32'(eh[3:1]));
        chk({tag, " Delta"}, 32'(Delta), 32'(eh[4:1]));
        chk({tag, " LocationSelect"}, 32'(LocationSelect), 32'(eh[0]));
    endtask

    // Reference: discard on reset/flush; otherwise pop the front if non-empty and
    // append Din if there was room before this edge.
    task automatic model_step(input logic rst, input logic fl, input logic dv,
                              input logic adv, input logic [IW-1:0] din);
        bit do_pop;
        bit do_push;
        if (rst || fl) begin
            model_q.delete();
        end else begin
            do_pop  = adv && (model_q.size() > 0);
            do_push = dv && (model_q.size() < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(din);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic dv,
                         input logic adv, input logic [IW-1:0] din);
        Reset     = rst;
        Flush     = fl;
        Din_valid = dv;
        Advance   = adv;
        Din       = din;
        model_step(rst, fl, dv, adv, din);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [IW-1:0] eh;
        eh = (model_q.size() > 0) ? model_q[0] : '0;
        check_all(tag, model_q.size() != 0, model_q.size(), model_q.size() != DEPTH, eh);
    endtask

    initial begin
        logic [IW-1:0] popped;
        logic [IW-1:0] expect_pop;
        Reset = 1'b0; Flush = 1'b0; Din_valid = 1'b0; Advance = 1'b0; Din = '0;

        //            rst fl dv adv din       ev cnt rdy head
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 4'd1, 1'b1, 16'h1234};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hA001, 1'b1, 4'd1, 1'b1, 16'hA001};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hB002, 1'b1, 4'd2, 1'b1, 16'hA001};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hC003, 1'b1, 4'd3, 1'b1, 16'hA001};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hD004, 1'b1, 4'd4, 1'b0, 16'hA001};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hE005, 1'b1, 4'd4, 1'b0, 16'hA001};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 4'd3, 1'b1, 16'hB002};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 4'd2, 1'b1, 16'hC003};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 4'd1, 1'b1, 16'hD004};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0000};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].dv, vecs[i].adv, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].ev, int'(vecs[i].ecnt),
                      vecs[i].erdy, vecs[i].ehead);
        end

        // Full queue with Advance and Din_valid: pop happens, push is refused.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h5000 + 16'(i));
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h5FFF);
        check_all("full push+pop", 1'b1, 3, 1'b1, 16'h5001);

        // Steady push+pop at Count=2 across pointer wrap.
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0101);
        expect_pop = 16'h0100;
        for (int i = 0; i < 20; i++) begin
            popped = {Opcode, Imm};
            drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0102 + 16'(i));
            chk($sformatf("stream pop%0d order", i), 32'(popped), 32'(expect_pop));
            expect_pop++;
            check_model($sformatf("stream%0d", i));
        end

        // Flush with concurrent push and advance at Count=3.
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h3300 + 16'(i));
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h7777);
        check_all("flush", 1'b0, 0, 1'b1, 16'h0000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h4444);
        check_all("after flush push", 1'b1, 1, 1'b1, 16'h4444);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_all("after flush drain", 1'b0, 0, 1'b1, 16'h0000);

        // Reset and Flush together at Count=2.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h9991);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h9992);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h9993);
        check_all("reset+flush", 1'b0, 0, 1'b1, 16'h0000);

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
                  IW'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
